// File: rtl/crypto_dp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crypto_dp_pkg                                                |
// | Description : Shared types, default widths and helpers for crypto_dp_core.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package crypto_dp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam int DEF_IW         = 15;
  localparam int DEF_OPW        = 5;
  localparam int DEF_OAW        = 4;
  localparam int DEF_AMW        = 2;
  localparam int DEF_BOW        = 4;
  localparam int DEF_IMEM_DEPTH = 32;
  localparam int DEF_DW         = 128;
  localparam int DEF_DDEPTH     = 4;

  // All-ones opcode ends the program; callers slice the low OPW bits.
  localparam logic [31:0] HALT_OP = '1;

  function automatic logic [31:0] sext_offset(input logic [31:0] off, input int bow);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = (i < bow) ? off[i] : off[bow-1];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dp_sync_fifo                                                 |
// | Description : First-word fall-through sync FIFO with occupancy count.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dp_sync_fifo #(
  parameter int DW     = 128,
  parameter int DDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      din_valid,
  input  logic [DW-1:0]             din,
  output logic                      din_ready,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [DW-1:0]             dout,
  output logic [$clog2(DDEPTH):0]   count
);

  localparam int AW = $clog2(DDEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DDEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DDEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = din_valid && !w_full;
  assign w_pop   = dout_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !reset) r_mem[r_wptr] <= din;
  end

  assign dout       = r_mem[r_rptr];
  assign din_ready  = !w_full;
  assign dout_valid = !w_empty;
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/crypto_dp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crypto_dp_core                                               |
// | Description : Instruction memory, PC, fetch/decode FSM and data FIFO.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module crypto_dp_core
  import crypto_dp_pkg::*;
#(
  parameter int IW         = DEF_IW,
  parameter int OPW        = DEF_OPW,
  parameter int OAW        = DEF_OAW,
  parameter int AMW        = DEF_AMW,
  parameter int BOW        = DEF_BOW,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int DW         = DEF_DW,
  parameter int DDEPTH     = DEF_DDEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_en,
  input  logic                          prog_valid,
  input  logic [IW-1:0]                 prog_data,
  output logic                          instr_written,
  output logic                          load_err,
  input  logic                          run,
  input  logic                          branch_en,
  input  logic                          issue_ready,
  output logic                          dec_valid,
  output logic [OPW-1:0]                opcode,
  output logic [OAW-1:0]                operand_addr,
  output logic [AMW-1:0]                operand_addr_mode,
  output logic [BOW-1:0]                branch_offset,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted,
  input  logic                          din_valid,
  input  logic [DW-1:0]                 din,
  output logic                          din_ready,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [DW-1:0]                 dout,
  output logic [$clog2(DDEPTH):0]       count,
  input  logic                          fifo_flush
);

  localparam int PCW    = $clog2(IMEM_DEPTH);
  localparam int OP_LSB = IW - OPW;
  localparam int OA_LSB = OP_LSB - OAW;
  localparam int AM_LSB = OA_LSB - AMW;

  logic [IW-1:0]  r_imem [IMEM_DEPTH];
  state_t         r_state;
  state_t         w_state_next;
  logic [PCW:0]   r_prog_len;
  logic [PCW-1:0] r_pc;
  logic [OPW-1:0] r_opcode;
  logic [OAW-1:0] r_oaddr;
  logic [AMW-1:0] r_amode;
  logic [BOW-1:0] r_boff;
  logic           r_dec_valid;
  logic           r_halted;
  logic           r_load_err;
  logic           r_instr_written;
  logic           w_dec_valid_d;
  logic           w_halted_d;
  logic           w_prog_full;
  logic           w_wr_req;
  logic           w_wr_acc;
  logic           w_handshake;
  logic           w_is_halt_op;
  logic           w_end;
  logic [PCW-1:0] w_next_pc;
  logic [IW-1:0]  w_rd_word;

  assign w_prog_full  = (r_prog_len == (PCW+1)'(IMEM_DEPTH));
  assign w_wr_req     = (r_state == ST_LOAD) && prog_en && prog_valid;
  assign w_wr_acc     = w_wr_req && !w_prog_full;
  assign w_handshake  = (r_state == ST_DECODE) && issue_ready;
  assign w_is_halt_op = (r_opcode == HALT_OP[OPW-1:0]);
  assign w_next_pc    = branch_en ? r_pc + PCW'(sext_offset(32'(r_boff), BOW))
                                  : r_pc + PCW'(1);
  assign w_end        = ({1'b0, w_next_pc} >= r_prog_len);
  assign w_rd_word    = r_imem[r_pc];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (prog_en)                         w_state_next = ST_LOAD;
        else if (run && (r_prog_len != '0))  w_state_next = ST_FETCH;
      end
      ST_LOAD:   if (!prog_en) w_state_next = ST_IDLE;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: if (w_handshake) w_state_next = (w_is_halt_op || w_end) ? ST_HALT : ST_FETCH;
      ST_HALT:   if (run) w_state_next = ST_FETCH;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so they appear registered.
  always_comb begin
    w_dec_valid_d = (w_state_next == ST_DECODE);
    w_halted_d    = (w_state_next == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_valid     <= 1'b0;
      r_halted        <= 1'b0;
      r_load_err      <= 1'b0;
      r_instr_written <= 1'b0;
      r_prog_len      <= '0;
      r_pc            <= '0;
      r_opcode        <= '0;
      r_oaddr         <= '0;
      r_amode         <= '0;
      r_boff          <= '0;
    end else begin
      r_dec_valid     <= w_dec_valid_d;
      r_halted        <= w_halted_d;
      r_instr_written <= w_wr_acc;
      if (w_wr_req && w_prog_full) r_load_err <= 1'b1;
      if ((r_state == ST_IDLE) && prog_en) r_prog_len <= '0;
      else if (w_wr_acc)                   r_prog_len <= r_prog_len + (PCW+1)'(1);
      if ((w_state_next == ST_FETCH) && ((r_state == ST_IDLE) || (r_state == ST_HALT)))
        r_pc <= '0;
      else if (w_handshake && !w_is_halt_op)
        r_pc <= w_next_pc;
      if (r_state == ST_FETCH) begin
        r_opcode <= w_rd_word[IW-1:OP_LSB];
        r_oaddr  <= w_rd_word[OP_LSB-1:OA_LSB];
        r_amode  <= w_rd_word[OA_LSB-1:AM_LSB];
        r_boff   <= w_rd_word[BOW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset) r_imem[r_prog_len[PCW-1:0]] <= prog_data;
  end

  assign instr_written     = r_instr_written;
  assign load_err          = r_load_err;
  assign dec_valid         = r_dec_valid;
  assign halted            = r_halted;
  assign pc                = r_pc;
  assign opcode            = r_opcode;
  assign operand_addr      = r_oaddr;
  assign operand_addr_mode = r_amode;
  assign branch_offset     = r_boff;

  dp_sync_fifo #(
    .DW     (DW),
    .DDEPTH (DDEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (fifo_flush),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .count      (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_crypto_dp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_crypto_dp_core                                            |
// | Description : Directed self-checking bench for crypto_dp_core.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_crypto_dp_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         prog_en, prog_valid, run, branch_en, issue_ready;
  logic [14:0]  prog_data;
  logic         instr_written, load_err, dec_valid, halted;
  logic [4:0]   opcode;
  logic [3:0]   operand_addr;
  logic [1:0]   operand_addr_mode;
  logic [3:0]   branch_offset;
  logic [4:0]   pc;
  logic         din_valid, din_ready, dout_valid, dout_ready, fifo_flush;
  logic [127:0] din, dout;
  logic [2:0]   count;

  logic [14:0]  prog [0:63];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           pulses;

  localparam logic [127:0] VA = 128'hA0A0_0000_0000_0000_0000_0000_0000_000A;
  localparam logic [127:0] VB = 128'hB0B0_0000_0000_0000_0000_0000_0000_000B;
  localparam logic [127:0] VC = 128'hC0C0_0000_0000_0000_0000_0000_0000_000C;
  localparam logic [127:0] VD = 128'hD0D0_0000_0000_0000_0000_0000_0000_000D;
  localparam logic [127:0] VE = 128'hE0E0_0000_0000_0000_0000_0000_0000_000E;
  localparam logic [127:0] VX = 128'hFFFF_0000_0000_0000_0000_0000_0000_FFFF;

  crypto_dp_core dut (
    .clk               (clk),
    .reset             (reset),
    .prog_en           (prog_en),
    .prog_valid        (prog_valid),
    .prog_data         (prog_data),
    .instr_written     (instr_written),
    .load_err          (load_err),
    .run               (run),
    .branch_en         (branch_en),
    .issue_ready       (issue_ready),
    .dec_valid         (dec_valid),
    .opcode            (opcode),
    .operand_addr      (operand_addr),
    .operand_addr_mode (operand_addr_mode),
    .branch_offset     (branch_offset),
    .pc                (pc),
    .halted            (halted),
    .din_valid         (din_valid),
    .din               (din),
    .din_ready         (din_ready),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .dout              (dout),
    .count             (count),
    .fifo_flush        (fifo_flush)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n, output int npulse);
    npulse = 0;
    prog_en = 1'b1;
    tick;
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1;
      prog_data  = prog[i];
      tick;
      if (instr_written) npulse++;
    end
    prog_valid = 1'b0;
    tick;
    prog_en = 1'b0;
    tick;
  endtask

  task automatic start_run;
    run = 1'b1;
    tick;
    run = 1'b0;
    tick;
  endtask

  task automatic issue_one(input logic br);
    issue_ready = 1'b1;
    branch_en   = br;
    tick;
    issue_ready = 1'b0;
    branch_en   = 1'b0;
    tick;
  endtask

  initial begin
    reset = 1'b1; prog_en = 0; prog_valid = 0; prog_data = '0; run = 0;
    branch_en = 0; issue_ready = 0; din_valid = 0; din = '0; dout_ready = 0; fifo_flush = 0;
    tick; tick;
    reset = 1'b0;
    check_value("rst_dec_valid", dec_valid, 0);
    check_value("rst_halted", halted, 0);
    check_value("rst_load_err", load_err, 0);
    check_value("rst_instr_written", instr_written, 0);
    check_value("rst_count", count, 0);
    check_value("rst_pc", pc, 0);
    check_value("rst_fields", {opcode, operand_addr, operand_addr_mode, branch_offset}, 0);
    check_value("rst_din_ready", din_ready, 1);
    check_value("rst_dout_valid", dout_valid, 0);

    // Three-word program ending in HALT_OP, with a stall on the first decode.
    prog[0] = 15'h0001; prog[1] = 15'h0402; prog[2] = 15'h7FFF;
    load_prog(3, pulses);
    check_value("load3_pulses", pulses, 3);
    check_value("load3_err", load_err, 0);
    run = 1'b1;
    tick;
    run = 1'b0;
    check_value("fetch_dec_valid", dec_valid, 0);
    tick;
    check_value("dec0", {dec_valid, pc, opcode, branch_offset}, {1'b1, 5'd0, 5'd0, 4'd1});
    for (int i = 0; i < 5; i++) begin
      tick;
      check_value("stall_hold", {dec_valid, pc, opcode, operand_addr, operand_addr_mode, branch_offset},
                  {1'b1, 5'd0, 5'd0, 4'd0, 2'd0, 4'd1});
    end
    issue_ready = 1'b1;
    tick;
    issue_ready = 1'b0;
    check_value("hs_dec_valid_low", {dec_valid, pc}, {1'b0, 5'd1});
    tick;
    check_value("dec1", {dec_valid, pc, opcode, branch_offset}, {1'b1, 5'd1, 5'd1, 4'd2});
    issue_one(1'b0);
    check_value("dec2_haltop", {dec_valid, pc, opcode}, {1'b1, 5'd2, 5'd31});
    issue_ready = 1'b1;
    tick;
    issue_ready = 1'b0;
    check_value("halt_op", {halted, dec_valid}, {1'b1, 1'b0});
    run = 1'b1;
    tick;
    run = 1'b0;
    check_value("rerun_halted_clear", {halted, dec_valid}, {1'b0, 1'b0});
    tick;
    check_value("rerun_dec0", {dec_valid, pc, opcode}, {1'b1, 5'd0, 5'd0});

    // Backward branch from pc 3, then forward branch past the end.
    reset = 1'b1; tick; reset = 1'b0;
    prog[0] = 15'h0000; prog[1] = 15'h0407; prog[2] = 15'h0800; prog[3] = 15'h0C0E;
    load_prog(4, pulses);
    start_run;
    issue_one(1'b0); issue_one(1'b0); issue_one(1'b0);
    check_value("dec3", {dec_valid, pc, opcode, branch_offset}, {1'b1, 5'd3, 5'd3, 4'hE});
    issue_one(1'b1);
    check_value("branch_back", {dec_valid, pc, opcode, branch_offset}, {1'b1, 5'd1, 5'd1, 4'd7});
    issue_one(1'b1);
    check_value("branch_past_end", {halted, dec_valid}, {1'b1, 1'b0});

    // Overflow load (33 writes) and PC wrap 30 + 7 -> 5.
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 32; i++) prog[i] = 15'((i << 10) | ((i == 30) ? 7 : 0));
    prog[32] = 15'h7FFF;
    load_prog(33, pulses);
    check_value("ovf_pulses", pulses, 32);
    check_value("ovf_load_err", load_err, 1);
    start_run;
    check_value("ovf_imem0", {dec_valid, pc, opcode}, {1'b1, 5'd0, 5'd0});
    for (int i = 0; i < 30; i++) issue_one(1'b0);
    check_value("dec30", {dec_valid, pc, opcode, branch_offset}, {1'b1, 5'd30, 5'd30, 4'd7});
    issue_one(1'b1);
    check_value("pc_wrap", {dec_valid, pc, opcode, halted}, {1'b1, 5'd5, 5'd5, 1'b0});

    // Reset in DECODE, then reset in LOAD.
    reset = 1'b1;
    tick;
    check_value("rst_decode", {dec_valid, pc, opcode, halted, load_err, instr_written}, 0);
    reset = 1'b0;
    prog_en = 1'b1;
    tick;
    prog_valid = 1'b1; prog_data = 15'h1234;
    tick;
    check_value("load_pulse", instr_written, 1);
    reset = 1'b1;
    tick;
    check_value("rst_load", {instr_written, load_err, dec_valid, halted}, 0);
    reset = 1'b0; prog_en = 1'b0; prog_valid = 1'b0;
    start_run;
    check_value("run_empty_ignored", {dec_valid, halted}, 0);

    // FIFO fill, overflow, push+pop, drain, underflow.
    din_valid = 1'b1; din = VA;
    tick;
    check_value("fifo_first", {dout_valid, count, dout}, {1'b1, 3'd1, VA});
    din = VB; tick;
    din = VC; tick;
    din = VD; tick;
    check_value("fifo_full", {din_ready, count, dout}, {1'b0, 3'd4, VA});
    din = VX; tick;
    check_value("fifo_push_full_drop", {count, dout}, {3'd4, VA});
    din_valid = 1'b0; dout_ready = 1'b1;
    tick;
    check_value("fifo_pop_a", {count, dout}, {3'd3, VB});
    din_valid = 1'b1; din = VE;
    tick;
    check_value("fifo_push_pop", {count, dout}, {3'd3, VC});
    din_valid = 1'b0;
    tick;
    check_value("fifo_pop_c", dout, VD);
    tick;
    check_value("fifo_pop_d", dout, VE);
    tick;
    check_value("fifo_empty", {count, dout_valid, din_ready}, {3'd0, 1'b0, 1'b1});
    tick;
    check_value("fifo_pop_empty", count, 0);
    dout_ready = 1'b0;

    // Flush wins over a same-cycle push.
    din_valid = 1'b1; din = VA; tick;
    din = VB; tick;
    check_value("fifo_two", count, 2);
    din = VC; fifo_flush = 1'b1;
    tick;
    check_value("fifo_flush", {count, dout_valid, din_ready}, {3'd0, 1'b0, 1'b1});
    fifo_flush = 1'b0; din_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
